// File: rtl/cv32e40px_x_offload_tracker.sv
// Multi-outstanding CORE-V-XIF offload tracker: ID allocation, destination scoreboard, issue/commit/result handling.
// Optional registered speculative commit with flush kill is enabled by CV32E40PX_X_SPEC_COMMIT_EN.
module cv32e40px_x_offload_tracker #(
    parameter int unsigned NUM_IDS = 4,
    parameter int unsigned NRS     = 3,
    parameter int unsigned ID_W    = $clog2(NUM_IDS)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               offload_req_i,
    input  logic               id_ready_i,
    input  logic [NRS*5-1:0]   rs_addr_i,
    input  logic [NRS-1:0]     rs_used_i,
    input  logic [4:0]         rd_addr_i,
    output logic               x_issue_valid_o,
    input  logic               x_issue_ready_i,
    input  logic               x_issue_resp_accept_i,
    input  logic               x_issue_resp_writeback_i,
    output logic [ID_W-1:0]    x_issue_id_o,
    output logic               x_commit_valid_o,
    output logic [ID_W-1:0]    x_commit_id_o,
    output logic               x_commit_kill_o,
    input  logic               x_result_valid_i,
    output logic               x_result_ready_o,
    input  logic [ID_W-1:0]    x_result_id_i,
    input  logic               x_result_we_i,
    input  logic               flush_i,
    output logic               stall_o,
    output logic               illegal_insn_o,
    output logic [ID_W:0]      outstanding_o,
    output logic               protocol_err_o
);

    localparam int unsigned CNT_W = ID_W + 1;

    typedef struct packed {
        logic       busy;
        logic       wb;
        logic [4:0] rd;
    } entry_t;

    entry_t            table_q [NUM_IDS];
    entry_t            table_d [NUM_IDS];
    logic [31:0]       sb_q, sb_d;
    logic [ID_W-1:0]   alloc_ptr_q, alloc_ptr_d;
    logic              offloaded_q, offloaded_d;
    logic              illegal_q, illegal_d;
    logic              perr_q, perr_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;

    logic              res_hit_c;
    logic [31:0]       res_clr_c;
    logic              raw_c;
    logic              waw_c;
    logic              no_id_c;
    logic              req_c;
    logic              issue_valid_c;
    logic              hs_c;
    logic              kill_c;
    logic [ID_W-1:0]   kill_id_c;

    // Dependency and issue qualification; a retiring result bypasses its RAW hazard
    always_comb begin
        res_hit_c = x_result_valid_i & table_q[x_result_id_i].busy;
        res_clr_c = '0;
        if (res_hit_c && x_result_we_i && table_q[x_result_id_i].wb) begin
            res_clr_c[table_q[x_result_id_i].rd] = 1'b1;
        end
        raw_c = 1'b0;
        for (int i = 0; i < int'(NRS); i++) begin
            if (rs_used_i[i] && sb_q[rs_addr_i[i*5 +: 5]] && !res_clr_c[rs_addr_i[i*5 +: 5]]) begin
                raw_c = 1'b1;
            end
        end
        waw_c         = sb_q[rd_addr_i];
        no_id_c       = table_q[alloc_ptr_q].busy;
        req_c         = offload_req_i & ~offloaded_q;
        issue_valid_c = req_c & ~raw_c & ~waw_c & ~no_id_c;
        hs_c          = issue_valid_c & x_issue_ready_i;
    end

    assign x_issue_valid_o  = issue_valid_c;
    assign x_issue_id_o     = alloc_ptr_q;
    assign stall_o          = (req_c & (raw_c | waw_c | no_id_c)) | (issue_valid_c & ~x_issue_ready_i);
    assign x_result_ready_o = 1'b1;
    assign illegal_insn_o   = illegal_q;
    assign protocol_err_o   = perr_q;
    assign outstanding_o    = outstanding_q;

`ifdef CV32E40PX_X_SPEC_COMMIT_EN
    logic            commit_valid_q;
    logic [ID_W-1:0] commit_id_q;
    logic            flush_issue_q;

    // Commit follows the accepted issue by one cycle; a flush on either cycle kills it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            commit_valid_q <= 1'b0;
            commit_id_q    <= '0;
            flush_issue_q  <= 1'b0;
        end else begin
            commit_valid_q <= hs_c & x_issue_resp_accept_i;
            commit_id_q    <= alloc_ptr_q;
            flush_issue_q  <= hs_c & x_issue_resp_accept_i & flush_i;
        end
    end

    assign kill_c           = commit_valid_q & (flush_i | flush_issue_q);
    assign kill_id_c        = commit_id_q;
    assign x_commit_valid_o = commit_valid_q;
    assign x_commit_id_o    = commit_id_q;
    assign x_commit_kill_o  = kill_c;
`else
    logic unused_flush;

    assign unused_flush     = flush_i;
    assign kill_c           = 1'b0;
    assign kill_id_c        = '0;
    assign x_commit_valid_o = hs_c & x_issue_resp_accept_i;
    assign x_commit_id_o    = alloc_ptr_q;
    assign x_commit_kill_o  = 1'b0;
`endif

    // Next-state: retire and kill clear first, then an accepted issue sets
    always_comb begin
        table_d       = table_q;
        sb_d          = sb_q & ~res_clr_c;
        alloc_ptr_d   = alloc_ptr_q;
        offloaded_d   = offloaded_q;
        illegal_d     = hs_c & ~x_issue_resp_accept_i;
        perr_d        = perr_q | (x_result_valid_i & ~table_q[x_result_id_i].busy);
        outstanding_d = '0;

        if (res_hit_c) begin
            table_d[x_result_id_i].busy = 1'b0;
        end
        if (kill_c && table_q[kill_id_c].busy) begin
            table_d[kill_id_c].busy = 1'b0;
            if (table_q[kill_id_c].wb) begin
                sb_d[table_q[kill_id_c].rd] = 1'b0;
            end
        end
        if (hs_c && x_issue_resp_accept_i) begin
            table_d[alloc_ptr_q].busy = 1'b1;
            table_d[alloc_ptr_q].wb   = x_issue_resp_writeback_i;
            table_d[alloc_ptr_q].rd   = rd_addr_i;
            if (x_issue_resp_writeback_i && (rd_addr_i != 5'd0)) begin
                sb_d[rd_addr_i] = 1'b1;
            end
            alloc_ptr_d = (alloc_ptr_q == ID_W'(NUM_IDS - 1)) ? '0 : alloc_ptr_q + ID_W'(1);
        end
        sb_d[0] = 1'b0;

        if (id_ready_i) begin
            offloaded_d = 1'b0;
        end else if (hs_c) begin
            offloaded_d = 1'b1;
        end

        for (int i = 0; i < int'(NUM_IDS); i++) begin
            outstanding_d = outstanding_d + CNT_W'(table_d[i].busy);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NUM_IDS); i++) begin
                table_q[i] <= '0;
            end
            sb_q          <= '0;
            alloc_ptr_q   <= '0;
            offloaded_q   <= 1'b0;
            illegal_q     <= 1'b0;
            perr_q        <= 1'b0;
            outstanding_q <= '0;
        end else begin
            table_q       <= table_d;
            sb_q          <= sb_d;
            alloc_ptr_q   <= alloc_ptr_d;
            offloaded_q   <= offloaded_d;
            illegal_q     <= illegal_d;
            perr_q        <= perr_d;
            outstanding_q <= outstanding_d;
        end
    end

endmodule
